// File: rtl/ex_mem_stage_buffer.sv
// ex_mem_stage_buffer
//   Two-entry elastic buffer between the execution and memory stages.
//   Captures each accepted execution result {control, alu, mem, ovf, zero,
//   comp} and presents the oldest one to the memory stage with a valid/ready
//   handshake. Exposes the youngest buffered ALU result for forwarding and
//   supports a synchronous flush.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   producer handshake; in_* result fields
//   out_valid/out_ready consumer handshake; out_* head-entry fields
//   flush               synchronous discard of all buffered entries
//   occupancy           number of buffered entries (0..2), registered
//   fwd_valid           at least one entry buffered
//   fwd_alu_data        ALU data of the most recently written entry
//   trap_pending        latched overflow trap
//
// Configuration
//   EX_MEM_OVF_TRAP_EN  when defined, pushing an overflowing result latches
//                       trap_pending, which blocks further pushes until
//                       flush or rst. When undefined trap_pending is 0.

module ex_mem_stage_buffer #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_control,
  input  logic [DATA_W-1:0] in_alu_data,
  input  logic [DATA_W-1:0] in_memory_data,
  input  logic              in_overflow_flag,
  input  logic              in_zero_flag,
  input  logic              in_compflg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_control,
  output logic [DATA_W-1:0] out_alu_data,
  output logic [DATA_W-1:0] out_memory_data,
  output logic              out_overflow_flag,
  output logic              out_zero_flag,
  output logic              out_compflg,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic              fwd_valid,
  output logic [DATA_W-1:0] fwd_alu_data,
  output logic              trap_pending
);

  logic [CTRL_W-1:0] ctrl_q [2];
  logic [DATA_W-1:0] alu_q  [2];
  logic [DATA_W-1:0] mem_q  [2];
  logic [1:0]        ovf_q;
  logic [1:0]        zero_q;
  logic [1:0]        comp_q;

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_ready  = (count_q != 2'd2) && !trap_pending;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        ctrl_q[i] <= '0;
        alu_q[i]  <= '0;
        mem_q[i]  <= '0;
      end
      ovf_q  <= '0;
      zero_q <= '0;
      comp_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && !flush) begin
        ctrl_q[wr_ptr_q] <= in_control;
        alu_q[wr_ptr_q]  <= in_alu_data;
        mem_q[wr_ptr_q]  <= in_memory_data;
        ovf_q[wr_ptr_q]  <= in_overflow_flag;
        zero_q[wr_ptr_q] <= in_zero_flag;
        comp_q[wr_ptr_q] <= in_compflg;
      end
    end
  end

  assign out_control       = ctrl_q[rd_ptr_q];
  assign out_alu_data      = alu_q[rd_ptr_q];
  assign out_memory_data   = mem_q[rd_ptr_q];
  assign out_overflow_flag = ovf_q[rd_ptr_q];
  assign out_zero_flag     = zero_q[rd_ptr_q];
  assign out_compflg       = comp_q[rd_ptr_q];

  assign occupancy    = count_q;
  assign fwd_valid    = out_valid;
  // Youngest entry sits one slot behind the write pointer; with 2 entries
  // that is simply the other slot.
  assign fwd_alu_data = alu_q[~wr_ptr_q];

`ifdef EX_MEM_OVF_TRAP_EN
  logic trap_q, trap_d;

  always_comb begin
    trap_d = trap_q;
    if (flush)
      trap_d = 1'b0;
    else if (push && in_overflow_flag)
      trap_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) trap_q <= 1'b0;
    else     trap_q <= trap_d;
  end

  assign trap_pending = trap_q;
`else
  assign trap_pending = 1'b0;
`endif

endmodule

// File: doc/ex_mem_stage_buffer.md
# ex_mem_stage_buffer

Receiving end of the execution-stage output bundle: `control_out`, `alu_data`, `memory_data`, `overflow_flag`, `zero_flag` and `compflg_out`. The block captures each valid execution result into a 2-entry elastic buffer and presents it to the memory stage with a valid/ready handshake. It also exposes the youngest buffered ALU result for operand forwarding, and supports a synchronous flush for branch or trap recovery. It sits between the execution stage and the memory stage and replaces the plain EX/MEM register.

## Interface
Parameters:
- `CTRL_W`, default 16: width of the packed `control_type` vector. It is carried opaquely and never decoded.
- `DATA_W`, default 32: width of the ALU and memory data fields.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  the execution stage presents a result.
- `in_ready`  out  1  the buffer can accept a result this cycle.
- `in_control`  in  CTRL_W  `control_out` from the execution stage.
- `in_alu_data`  in  DATA_W  ALU result.
- `in_memory_data`  in  DATA_W  store data.
- `in_overflow_flag`, `in_zero_flag`, `in_compflg`  in  1 each  execution flags.
- `out_valid`  out  1  the head entry is valid.
- `out_ready`  in  1  the memory stage accepts the head entry.
- `out_control`, `out_alu_data`, `out_memory_data`, `out_overflow_flag`, `out_zero_flag`, `out_compflg`  out  widths as inputs  head entry fields.
- `flush`  in  1  synchronous discard of all buffered entries.
- `occupancy`  out  2  number of valid entries (0..2).
- `fwd_valid`  out  1  at least one entry is buffered.
- `fwd_alu_data`  out  DATA_W  ALU data of the most recently written entry.
- `trap_pending`  out  1  an overflow trap is latched (see Configuration).

## Operation
- Storage is 2 entries, each holding {control, alu, mem, ovf, zero, comp}. There is a 1-bit write pointer, a 1-bit read pointer and a 2-bit count. Both pointers wrap 1→0.
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready = (count != 2) && !trap_pending`. It depends only on registered state and has no combinational path from `out_ready`.
- `out_valid = (count != 0)`. The `out_*` fields are driven from the entry at the read pointer.
- Count update:
  - push only: count +1.
  - pop only: count −1.
  - push and pop together: count unchanged, and both pointers advance.
- At count == 2, a push is impossible because `in_ready` is 0. A pop frees one slot, visible as `in_ready = 1` on the next cycle.
- At count == 0, a pop is impossible. A push in the same cycle is not bypassed to the outputs.
- Flush:
  - Next state: count = 0, both pointers = 0.
  - A push or pop in the same cycle is ignored.
  - Entry data registers are not cleared.
  - `trap_pending` is cleared.
- Flush has priority over push, pop and trap set.
- Forwarding:
  - `fwd_alu_data` is the entry at (write pointer − 1) mod 2.
  - `fwd_valid = out_valid`.
  - When `fwd_valid` is 0, `fwd_alu_data` is don't-care, but it must be driven from a register, not X.
- While `out_valid = 1` and `out_ready = 0`, all `out_*` fields remain stable.

## Timing
- Reset values (asynchronous, as soon as `rst` rises):
  - count = 0 and both pointers = 0.
  - All entry registers = 0.
  - `out_valid` = 0, `in_ready` = 1, `occupancy` = 0.
  - `fwd_valid` = 0, `fwd_alu_data` = 0, `trap_pending` = 0.
- Deasserting reset mid-transfer loses every entry, and the first cycle after release behaves as empty.
- Latency: a push in cycle N makes `out_valid` rise in cycle N+1 with that entry's data.
- Throughput: 1 entry per cycle sustained when `out_ready` is held high.
- `occupancy` and `trap_pending` are registered outputs. `in_ready` and `out_valid` are single-gate decodes of registered state.

## Configuration
- Macro `EX_MEM_OVF_TRAP_EN`.
- Defined:
  - A push with `in_overflow_flag = 1` sets `trap_pending` in the next cycle.
  - `trap_pending` is sticky until `flush` or `rst`, and while set it forces `in_ready = 0`.
  - Entries already buffered, including the overflowing one, still drain normally.
- Undefined:
  - `trap_pending` is tied to 0 and no trap logic is generated.
  - The overflow flag only passes through to `out_overflow_flag`.

## Test plan
- Reset then single push: `in_alu_data` = 0x0000_00A5 in cycle 1, `out_ready` = 1 → cycle 2 shows `out_valid` = 1, `out_alu_data` = 0x0000_00A5, `occupancy` = 1. Cycle 3 shows `occupancy` = 0.
- Backpressure fill: `out_ready` = 0, push 0x11 then 0x22 → `occupancy` = 2 and `in_ready` = 0. The output holds 0x11 stable and `fwd_alu_data` = 0x22. Raising `out_ready` pops 0x11 then 0x22 in order.
- Simultaneous push and pop at count 1, with head 0x33 and pushing 0x44 → `occupancy` stays 1, next head = 0x44, and the pointers wrap correctly over 4 iterations.
- Flush with count = 2 plus a same-cycle push of 0x55 → next cycle `out_valid` = 0, `occupancy` = 0, and 0x55 is never emitted.
- With `EX_MEM_OVF_TRAP_EN`: push with overflow = 1 → `trap_pending` = 1 and `in_ready` = 0 until flush, and the entry still drains. Without the macro, the same stimulus leaves `trap_pending` = 0 and `in_ready` = 1.
- Asynchronous `rst` pulse mid-stream at count 2 → outputs go immediately to their reset values, and the first post-reset push appears one cycle later.
